core_debug_mc: RTL and testbench

//  Multi-core debug controller; parametrised successor of the single-core debug unit.

---
 rtl/core_debug_pkg.sv | 54 +++++
 rtl/core_debug_timeout.sv | 43 ++++
 rtl/core_debug_mc.sv | 171 +++++++++++++++++
 tb/tb_core_debug_mc.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_debug_pkg.sv
// Shared encodings for the multi-core debug controller: command codes,
// error codes, FSM state encoding, register targets and command helpers.
package core_debug_pkg;

  // Host command codes
  localparam logic [3:0] CMD_READ_REG  = 4'h0;
  localparam logic [3:0] CMD_WRITE_REG = 4'h1;
  localparam logic [3:0] CMD_GO        = 4'h8;
  localparam logic [3:0] CMD_STEP      = 4'hA;
  localparam logic [3:0] CMD_STOP      = 4'hF;

  // Error codes returned in the response data word
  localparam logic [31:0] ERR_BAD_CMD      = 32'd1;
  localparam logic [31:0] ERR_BAD_CORE     = 32'd2;
  localparam logic [31:0] ERR_CORE_RUNNING = 32'd3;
  localparam logic [31:0] ERR_TIMEOUT      = 32'd4;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_CORE_WAIT = 2'd1;
  localparam logic [1:0] ST_REG_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP      = 2'd3;

  // Register target indices of the host debug target map
  localparam logic [7:0] TGT_GPR_FIRST = 8'h00;
  localparam logic [7:0] TGT_GPR_LAST  = 8'h1F;

  // Command fields captured at acceptance (core index is width-parameterised, kept separately)
  typedef struct packed {
    logic [3:0]  cmd;
    logic [7:0]  target;
    logic [31:0] wdata;
  } dbg_cmd_t;

  function automatic logic cmd_is_valid(input logic [3:0] cmd);
    return (cmd == CMD_READ_REG) || (cmd == CMD_WRITE_REG) || (cmd == CMD_GO) ||
           (cmd == CMD_STEP) || (cmd == CMD_STOP);
  endfunction

  function automatic logic cmd_is_reg(input logic [3:0] cmd);
    return (cmd == CMD_READ_REG) || (cmd == CMD_WRITE_REG);
  endfunction

  // Register access and single-step are only meaningful on a halted core
  function automatic logic cmd_needs_halt(input logic [3:0] cmd);
    return cmd_is_reg(cmd) || (cmd == CMD_STEP);
  endfunction

  // A core acknowledging STOP or STEP ends up halted; GO leaves it running
  function automatic logic cmd_leaves_halted(input logic [3:0] cmd);
    return (cmd == CMD_STOP) || (cmd == CMD_STEP);
  endfunction

endpackage

// File: rtl/core_debug_timeout.sv
// Loadable saturating cycle counter with a terminal-count flag, used to
// bound how long the controller waits for a core or register-port ack.
module core_debug_timeout #(
  parameter int P_LIMIT = 1024,
  parameter int P_CNT_W = $clog2(P_LIMIT)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic inc_i,
  output logic tc_o
);

  localparam logic [P_CNT_W-1:0] TC_VAL = P_CNT_W'(P_LIMIT - 1);

  logic [P_CNT_W-1:0] cnt_q, cnt_d;

  function automatic logic [P_CNT_W-1:0] sat_inc(input logic [P_CNT_W-1:0] v);
    return (v == TC_VAL) ? v : v + P_CNT_W'(1);
  endfunction

  // Load clears the count; otherwise count up and hold at terminal count
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = sat_inc(cnt_q);
    end
  end

  // Count register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == TC_VAL);

endmodule

// File: rtl/core_debug_mc.sv
// Multi-core debug controller: accepts one host command at a time, runs the
// run-control or register-access handshake for the addressed core, and
// returns exactly one response (data or coded error) per command.
module core_debug_mc
  import core_debug_pkg::*;
#(
  parameter int P_CORE_NUM    = 4,
  parameter int P_CORE_W      = (P_CORE_NUM > 1) ? $clog2(P_CORE_NUM) : 1,
  parameter int P_ACK_TIMEOUT = 1024
) (
  input  logic                  iCLOCK,
  input  logic                  iRESET,
  input  logic                  iCMD_REQ,
  output logic                  oCMD_BUSY,
  input  logic [3:0]            iCMD_COMMAND,
  input  logic [P_CORE_W-1:0]   iCMD_CORE,
  input  logic [7:0]            iCMD_TARGET,
  input  logic [31:0]           iCMD_DATA,
  output logic                  oRESP_VALID,
  output logic                  oRESP_ERROR,
  output logic [31:0]           oRESP_DATA,
  output logic [P_CORE_NUM-1:0] oDEBUG_CORE_REQ,
  output logic                  oDEBUG_CORE_STOP,
  output logic                  oDEBUG_CORE_START,
  output logic                  oDEBUG_CORE_STEP,
  input  logic [P_CORE_NUM-1:0] iDEBUG_CORE_ACK,
  output logic [P_CORE_NUM-1:0] oCORE_HALTED,
  output logic                  oREG_REQ,
  output logic                  oREG_WRITE,
  output logic [P_CORE_W-1:0]   oREG_CORE,
  output logic [7:0]            oREG_TARGET,
  output logic [31:0]           oREG_WDATA,
  input  logic                  iREG_ACK,
  input  logic [31:0]           iREG_RDATA
);

  logic [1:0]            state_q, state_d;
  logic [P_CORE_NUM-1:0] halted_q, halted_d;
  logic                  resp_err_q, resp_err_d;
  logic [31:0]           resp_data_q, resp_data_d;
  dbg_cmd_t              cap_q;
  logic [P_CORE_W-1:0]   core_q;

  logic accept, in_core, in_reg, tc, core_ok, core_halted, ack_sel;

  assign accept  = (state_q == ST_IDLE) && iCMD_REQ;
  assign in_core = (state_q == ST_CORE_WAIT);
  assign in_reg  = (state_q == ST_REG_WAIT);
  assign core_ok = (int'(iCMD_CORE) < P_CORE_NUM);

  // Halted status of the requested core; out-of-range indices read as running
  always_comb begin
    core_halted = 1'b0;
    for (int c = 0; c < P_CORE_NUM; c++) begin
      if (int'(iCMD_CORE) == c) core_halted = halted_q[c];
    end
  end

  // Only the captured core's ack bit is observed
  always_comb begin
    ack_sel = 1'b0;
    for (int c = 0; c < P_CORE_NUM; c++) begin
      if (int'(core_q) == c) ack_sel = iDEBUG_CORE_ACK[c];
    end
  end

  // Wait-state counter restarts from zero on every entry into a wait state
  core_debug_timeout #(.P_LIMIT(P_ACK_TIMEOUT)) u_timeout (
    .clk_i  (iCLOCK),
    .rst_i  (iRESET),
    .load_i (!(in_core || in_reg)),
    .inc_i  (in_core || in_reg),
    .tc_o   (tc)
  );

  // Next-state, halted tracking and response word; an ack beats the timeout
  always_comb begin
    state_d     = state_q;
    halted_d    = halted_q;
    resp_err_d  = resp_err_q;
    resp_data_d = resp_data_q;
    case (state_q)
      ST_IDLE: begin
        if (iCMD_REQ) begin
          if (!core_ok) begin
            state_d = ST_RESP; resp_err_d = 1'b1; resp_data_d = ERR_BAD_CORE;
          end else if (!cmd_is_valid(iCMD_COMMAND)) begin
            state_d = ST_RESP; resp_err_d = 1'b1; resp_data_d = ERR_BAD_CMD;
          end else if (cmd_needs_halt(iCMD_COMMAND) && !core_halted) begin
            state_d = ST_RESP; resp_err_d = 1'b1; resp_data_d = ERR_CORE_RUNNING;
          end else if (cmd_is_reg(iCMD_COMMAND)) begin
            state_d = ST_REG_WAIT;
          end else begin
            state_d = ST_CORE_WAIT;
          end
        end
      end
      ST_CORE_WAIT: begin
        if (ack_sel) begin
          state_d = ST_RESP; resp_err_d = 1'b0; resp_data_d = '0;
          for (int c = 0; c < P_CORE_NUM; c++) begin
            if (int'(core_q) == c) halted_d[c] = cmd_leaves_halted(cap_q.cmd);
          end
        end else if (tc) begin
          state_d = ST_RESP; resp_err_d = 1'b1; resp_data_d = ERR_TIMEOUT;
        end
      end
      ST_REG_WAIT: begin
        if (iREG_ACK) begin
          state_d     = ST_RESP;
          resp_err_d  = 1'b0;
          resp_data_d = (cap_q.cmd == CMD_WRITE_REG) ? 32'd0 : iREG_RDATA;
        end else if (tc) begin
          state_d = ST_RESP; resp_err_d = 1'b1; resp_data_d = ERR_TIMEOUT;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Control state; reset abandons any handshake in flight without a response
  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      state_q     <= ST_IDLE;
      halted_q    <= '0;
      resp_err_q  <= 1'b0;
      resp_data_q <= '0;
    end else begin
      state_q     <= state_d;
      halted_q    <= halted_d;
      resp_err_q  <= resp_err_d;
      resp_data_q <= resp_data_d;
    end
  end

  // Command fields captured on acceptance; outputs using them are state-gated
  always_ff @(posedge iCLOCK) begin
    if (accept) begin
      cap_q.cmd    <= iCMD_COMMAND;
      cap_q.target <= iCMD_TARGET;
      cap_q.wdata  <= iCMD_DATA;
      core_q       <= iCMD_CORE;
    end
  end

  // Run-control request: one-hot on the captured core while waiting for its ack
  always_comb begin
    oDEBUG_CORE_REQ = '0;
    for (int c = 0; c < P_CORE_NUM; c++) begin
      oDEBUG_CORE_REQ[c] = in_core && (int'(core_q) == c);
    end
  end

  assign oDEBUG_CORE_STOP  = in_core && (cap_q.cmd == CMD_STOP);
  assign oDEBUG_CORE_START = in_core && (cap_q.cmd == CMD_GO);
  assign oDEBUG_CORE_STEP  = in_core && (cap_q.cmd == CMD_STEP);

  assign oREG_REQ    = in_reg;
  assign oREG_WRITE  = in_reg && (cap_q.cmd == CMD_WRITE_REG);
  assign oREG_CORE   = in_reg ? core_q : '0;
  assign oREG_TARGET = in_reg ? cap_q.target : 8'd0;
  assign oREG_WDATA  = in_reg ? cap_q.wdata : 32'd0;

  assign oCMD_BUSY    = (state_q != ST_IDLE);
  assign oRESP_VALID  = (state_q == ST_RESP);
  assign oRESP_ERROR  = (state_q == ST_RESP) && resp_err_q;
  assign oRESP_DATA   = resp_data_q;
  assign oCORE_HALTED = halted_q;

endmodule

// File: tb/tb_core_debug_mc.sv
// Bench for core_debug_mc: directed scenarios plus randomized commands,
// checked every cycle against a transaction-level model of the controller.
module tb_core_debug_mc;

  localparam int NC = 4;
  // Index one bit wider than needed so out-of-range cores can be presented
  localparam int CW = 3;
  localparam int TO = 16;

  logic          iCLOCK = 1'b0;
  logic          iRESET;
  logic          iCMD_REQ;
  logic          oCMD_BUSY;
  logic [3:0]    iCMD_COMMAND;
  logic [CW-1:0] iCMD_CORE;
  logic [7:0]    iCMD_TARGET;
  logic [31:0]   iCMD_DATA;
  logic          oRESP_VALID, oRESP_ERROR;
  logic [31:0]   oRESP_DATA;
  logic [NC-1:0] oDEBUG_CORE_REQ;
  logic          oDEBUG_CORE_STOP, oDEBUG_CORE_START, oDEBUG_CORE_STEP;
  logic [NC-1:0] iDEBUG_CORE_ACK;
  logic [NC-1:0] oCORE_HALTED;
  logic          oREG_REQ, oREG_WRITE;
  logic [CW-1:0] oREG_CORE;
  logic [7:0]    oREG_TARGET;
  logic [31:0]   oREG_WDATA;
  logic          iREG_ACK;
  logic [31:0]   iREG_RDATA;

  core_debug_mc #(.P_CORE_NUM(NC), .P_CORE_W(CW), .P_ACK_TIMEOUT(TO)) dut (
    .iCLOCK(iCLOCK), .iRESET(iRESET), .iCMD_REQ(iCMD_REQ), .oCMD_BUSY(oCMD_BUSY),
    .iCMD_COMMAND(iCMD_COMMAND), .iCMD_CORE(iCMD_CORE), .iCMD_TARGET(iCMD_TARGET),
    .iCMD_DATA(iCMD_DATA), .oRESP_VALID(oRESP_VALID), .oRESP_ERROR(oRESP_ERROR),
    .oRESP_DATA(oRESP_DATA), .oDEBUG_CORE_REQ(oDEBUG_CORE_REQ),
    .oDEBUG_CORE_STOP(oDEBUG_CORE_STOP), .oDEBUG_CORE_START(oDEBUG_CORE_START),
    .oDEBUG_CORE_STEP(oDEBUG_CORE_STEP), .iDEBUG_CORE_ACK(iDEBUG_CORE_ACK),
    .oCORE_HALTED(oCORE_HALTED), .oREG_REQ(oREG_REQ), .oREG_WRITE(oREG_WRITE),
    .oREG_CORE(oREG_CORE), .oREG_TARGET(oREG_TARGET), .oREG_WDATA(oREG_WDATA),
    .iREG_ACK(iREG_ACK), .iREG_RDATA(iREG_RDATA)
  );

  always #5 iCLOCK = ~iCLOCK;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  // Model: halted flag per core, plus the outputs expected in the current cycle
  bit            mh [NC];
  logic          exp_busy, exp_rv, exp_re;
  logic [31:0]   exp_rdata;
  logic [NC-1:0] exp_req, exp_halted;
  logic          exp_stop, exp_start, exp_step;
  logic          exp_regreq, exp_regwr;
  logic [CW-1:0] exp_regcore;
  logic [7:0]    exp_regtgt;
  logic [31:0]   exp_regwd;

  // Observations of the last transaction, pinned against literals
  int            obs_req_cycles, obs_regreq_cycles;
  logic [NC-1:0] obs_req_val;
  logic          obs_stop, obs_regwr, obs_resp_err;
  logic [31:0]   obs_wdata, obs_resp_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  function automatic logic [NC-1:0] model_halted();
    logic [NC-1:0] v;
    for (int i = 0; i < NC; i++) v[i] = mh[i];
    return v;
  endfunction

  task automatic exp_idle();
    exp_busy = 1'b0; exp_rv = 1'b0; exp_re = 1'b0;
    exp_req = '0; exp_stop = 1'b0; exp_start = 1'b0; exp_step = 1'b0;
    exp_regreq = 1'b0; exp_regwr = 1'b0;
    exp_halted = model_halted();
  endtask

  // Garbage on the command port while busy must be ignored
  task automatic drive_noise(input bit noise);
    if (noise) begin
      iCMD_REQ = 1'($urandom); iCMD_COMMAND = 4'($urandom); iCMD_CORE = CW'($urandom);
      iCMD_TARGET = 8'($urandom); iCMD_DATA = $urandom;
    end else begin
      iCMD_REQ = 1'b0;
    end
  endtask

  // Per-cycle comparison of every meaningful output against the model
  always @(negedge iCLOCK) begin
    if (chk_en) begin
      chk("busy", oCMD_BUSY, exp_busy);
      chk("resp_valid", oRESP_VALID, exp_rv);
      if (exp_rv) chk("resp_error", oRESP_ERROR, exp_re);
      chk("resp_data", oRESP_DATA, exp_rdata);
      chk("core_req", oDEBUG_CORE_REQ, exp_req);
      if (exp_req != '0) begin
        chk("core_stop", oDEBUG_CORE_STOP, exp_stop);
        chk("core_start", oDEBUG_CORE_START, exp_start);
        chk("core_step", oDEBUG_CORE_STEP, exp_step);
      end
      chk("halted", oCORE_HALTED, exp_halted);
      chk("reg_req", oREG_REQ, exp_regreq);
      if (exp_regreq) begin
        chk("reg_write", oREG_WRITE, exp_regwr);
        chk("reg_core", oREG_CORE, exp_regcore);
        chk("reg_target", oREG_TARGET, exp_regtgt);
        chk("reg_wdata", oREG_WDATA, exp_regwd);
      end
    end
  end

  // One command, start to finish. Called at posedge+1 of an idle cycle.
  // ack_at: wait-cycle index (0 = first) on which the ack is given; out of range = never.
  task automatic issue(input logic [3:0] cmd, input int core, input logic [7:0] tgt,
                       input logic [31:0] wd, input int ack_at, input logic [NC-1:0] other,
                       input logic [31:0] rdv, input bit noise);
    int err, k;
    bit done, timed, is_reg, ack;
    logic [31:0] rd_seen;
    iCMD_REQ = 1'b1; iCMD_COMMAND = cmd; iCMD_CORE = CW'(core);
    iCMD_TARGET = tgt; iCMD_DATA = wd;
    exp_idle();
    @(posedge iCLOCK); #1;
    drive_noise(noise);
    obs_req_cycles = 0; obs_regreq_cycles = 0; obs_req_val = '0;
    obs_stop = 1'b0; obs_regwr = 1'b0; obs_wdata = '0;
    if (core >= NC) err = 2;
    else if (!(cmd inside {4'h0, 4'h1, 4'h8, 4'hA, 4'hF})) err = 1;
    else if ((cmd inside {4'h0, 4'h1, 4'hA}) && !mh[core]) err = 3;
    else err = 0;
    if (err != 0) begin
      exp_busy = 1'b1; exp_rv = 1'b1; exp_re = 1'b1; exp_rdata = 32'(err);
      obs_resp_data = oRESP_DATA; obs_resp_err = oRESP_ERROR;
    end else begin
      is_reg = (cmd inside {4'h0, 4'h1});
      k = 0; done = 1'b0; timed = 1'b0; rd_seen = '0;
      while (!done) begin
        exp_busy = 1'b1; exp_rv = 1'b0;
        if (is_reg) begin
          exp_regreq = 1'b1; exp_regwr = (cmd == 4'h1); exp_regcore = CW'(core);
          exp_regtgt = tgt; exp_regwd = wd; exp_req = '0;
        end else begin
          exp_regreq = 1'b0; exp_req = NC'(1) << core;
          exp_stop = (cmd == 4'hF); exp_start = (cmd == 4'h8); exp_step = (cmd == 4'hA);
        end
        if (oDEBUG_CORE_REQ != '0) begin
          obs_req_cycles++; obs_req_val = oDEBUG_CORE_REQ; obs_stop = oDEBUG_CORE_STOP;
        end
        if (oREG_REQ) begin
          obs_regreq_cycles++; obs_regwr = oREG_WRITE; obs_wdata = oREG_WDATA;
        end
        ack = (k == ack_at);
        if (is_reg) begin
          iREG_ACK = ack; iREG_RDATA = ack ? rdv : $urandom; iDEBUG_CORE_ACK = '0;
        end else begin
          iREG_ACK = 1'b0; iDEBUG_CORE_ACK = (other & ~exp_req) | (ack ? exp_req : '0);
        end
        if (ack) begin
          done = 1'b1; rd_seen = rdv;
        end else if (k == TO - 1) begin
          done = 1'b1; timed = 1'b1;
        end
        @(posedge iCLOCK); #1;
        drive_noise(noise);
        k++;
      end
      iREG_ACK = 1'b0; iDEBUG_CORE_ACK = '0;
      if (!timed && !is_reg) mh[core] = (cmd == 4'hF) || (cmd == 4'hA);
      exp_busy = 1'b1; exp_rv = 1'b1; exp_re = timed;
      exp_rdata = timed ? 32'd4 : ((cmd == 4'h0) ? rd_seen : 32'd0);
      exp_req = '0; exp_regreq = 1'b0; exp_halted = model_halted();
      obs_resp_data = oRESP_DATA; obs_resp_err = oRESP_ERROR;
    end
    @(posedge iCLOCK); #1;
    iCMD_REQ = 1'b0;
    exp_idle();
  endtask

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog expired t=%0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  int       sel, rcore, rack;
  logic [3:0] rcmd;

  initial begin
    iRESET = 1'b1; iCMD_REQ = 1'b0; iCMD_COMMAND = '0; iCMD_CORE = '0; iCMD_TARGET = '0;
    iCMD_DATA = '0; iDEBUG_CORE_ACK = '0; iREG_ACK = 1'b0; iREG_RDATA = '0;
    for (int i = 0; i < NC; i++) mh[i] = 1'b0;
    exp_rdata = '0;
    exp_idle();
    repeat (3) @(posedge iCLOCK);
    #1;
    chk("rst_busy", oCMD_BUSY, 0);
    chk("rst_resp_valid", oRESP_VALID, 0);
    chk("rst_resp_data", oRESP_DATA, 0);
    chk("rst_core_req", oDEBUG_CORE_REQ, 0);
    chk("rst_halted", oCORE_HALTED, 0);
    chk("rst_reg_req", oREG_REQ, 0);
    iRESET = 1'b0;
    chk_en = 1'b1;
    @(posedge iCLOCK); #1;

    // STOP core 2, ack on third wait cycle
    issue(4'hF, 2, 8'h00, 32'h0, 2, '0, 32'h0, 1'b0);
    chk("d1_req_cycles", obs_req_cycles, 3);
    chk("d1_req_vec", obs_req_val, 4'b0100);
    chk("d1_stop", obs_stop, 1);
    chk("d1_resp_err", obs_resp_err, 0);
    chk("d1_halted", oCORE_HALTED, 4'b0100);

    // WRITE then READ register 5 of halted core 2
    issue(4'h1, 2, 8'h05, 32'hDEAD_BEEF, 1, '0, 32'h0, 1'b0);
    chk("d2_reg_write", obs_regwr, 1);
    chk("d2_wdata", obs_wdata, 32'hDEAD_BEEF);
    chk("d2_reg_cycles", obs_regreq_cycles, 2);
    chk("d2_resp", {obs_resp_err, obs_resp_data[30:0]}, 0);
    issue(4'h0, 2, 8'h05, 32'h0, 1, '0, 32'hDEAD_BEEF, 1'b0);
    chk("d3_resp_data", obs_resp_data, 32'hDEAD_BEEF);
    chk("d3_resp_err", obs_resp_err, 0);

    // Error responses: running core, bad command, bad core
    issue(4'h0, 1, 8'h05, 32'h0, 0, '0, 32'h1234, 1'b0);
    chk("d4_resp_err", obs_resp_err, 1);
    chk("d4_resp_data", obs_resp_data, 3);
    chk("d4_no_reg_req", obs_regreq_cycles, 0);
    issue(4'h3, 0, 8'h00, 32'h0, 0, '0, 32'h0, 1'b0);
    chk("d5_resp_data", obs_resp_data, 1);
    issue(4'h8, 5, 8'h00, 32'h0, 0, '0, 32'h0, 1'b0);
    chk("d6_resp_data", obs_resp_data, 2);

    // Halt core 0, then STEP it with no ack: timeout leaves it halted
    issue(4'hF, 0, 8'h00, 32'h0, 0, '0, 32'h0, 1'b0);
    issue(4'hA, 0, 8'h00, 32'h0, -1, '0, 32'h0, 1'b0);
    chk("d7_req_cycles", obs_req_cycles, 16);
    chk("d7_resp_err", obs_resp_err, 1);
    chk("d7_resp_data", obs_resp_data, 4);
    chk("d7_halted0", oCORE_HALTED[0], 1);

    // GO core 0, wrong core's ack held throughout, real ack on terminal count
    issue(4'h8, 0, 8'h00, 32'h0, TO - 1, 4'b0010, 32'h0, 1'b0);
    chk("d8_req_cycles", obs_req_cycles, 16);
    chk("d8_resp_err", obs_resp_err, 0);
    chk("d8_resp_data", obs_resp_data, 0);
    chk("d8_halted0", oCORE_HALTED[0], 0);
    chk("d8_model", model_halted(), 4'b0100);

    // Reset in the middle of a run-control handshake
    iCMD_REQ = 1'b1; iCMD_COMMAND = 4'hF; iCMD_CORE = 3'd1;
    @(posedge iCLOCK); #1;
    iCMD_REQ = 1'b0;
    chk_en = 1'b0;
    chk("r_req_pre", oDEBUG_CORE_REQ, 4'b0010);
    #2 iRESET = 1'b1;
    #1;
    chk("r_req", oDEBUG_CORE_REQ, 0);
    chk("r_stop", oDEBUG_CORE_STOP, 0);
    chk("r_busy", oCMD_BUSY, 0);
    chk("r_valid", oRESP_VALID, 0);
    chk("r_data", oRESP_DATA, 0);
    chk("r_halted", oCORE_HALTED, 0);
    @(posedge iCLOCK); #1;
    iRESET = 1'b0;
    for (int i = 0; i < NC; i++) mh[i] = 1'b0;
    exp_rdata = '0;
    exp_idle();
    chk_en = 1'b1;
    @(posedge iCLOCK); #1;
    issue(4'hF, 2, 8'h00, 32'h0, 0, '0, 32'h0, 1'b0);
    chk("r_post_err", obs_resp_err, 0);
    chk("r_post_halted", oCORE_HALTED, 4'b0100);

    // Randomized commands with bus noise
    for (int t = 0; t < 300; t++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1, 9: rcmd = 4'h0;
        2:       rcmd = 4'h1;
        3, 4:    rcmd = 4'h8;
        5:       rcmd = 4'hA;
        6, 7:    rcmd = 4'hF;
        default: rcmd = 4'($urandom);
      endcase
      rcore = ($urandom_range(0, 7) == 0) ? $urandom_range(4, 7) : $urandom_range(0, 3);
      rack  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : $urandom_range(0, 4);
      issue(rcmd, rcore, 8'($urandom), $urandom, rack, NC'($urandom), $urandom, 1'b1);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge iCLOCK);
        #1;
      end
    end

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
